// File: rtl/game_ctrl.sv
// Round sequencer for the two-player factorization game: title, ready handshake,
// countdown, timed answer phase, round scoring and final winner report.
module game_ctrl #(
  parameter int unsigned CLK_DIV   = 100_000_000,
  parameter int unsigned COUNT_SEC = 3,
  parameter int unsigned PLAY_SEC  = 30,
  parameter int unsigned ROUNDS    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       OK,
  input  logic       OK_2,
  input  logic       ANS_1P,
  input  logic       ANS_2P,
  output logic [3:0] STATE,
  output logic [5:0] SEC,
  output logic [1:0] ROUND,
  output logic [1:0] SCORE_1P,
  output logic [1:0] SCORE_2P,
  output logic [1:0] WINNER
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  localparam logic [3:0] S_TITLE     = 4'b0001;
  localparam logic [3:0] S_READY     = 4'b0010;
  localparam logic [3:0] S_COUNTDOWN = 4'b0100;
  localparam logic [3:0] S_PLAY      = 4'b1000;
  localparam logic [3:0] S_ROUND_END = 4'b0011;
  localparam logic [3:0] S_RESULT    = 4'b0101;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_1P   = 2'b01;
  localparam logic [1:0] W_2P   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  logic [3:0]    state_n;
  logic [5:0]    sec_n;
  logic [1:0]    round_n;
  logic [1:0]    score_1p_n;
  logic [1:0]    score_2p_n;
  logic [1:0]    winner_n;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  logic [PW-1:0] presc_inc;
  logic          start_q;
  logic          start_edge;
  logic          tick;

  assign start_edge = START & ~start_q;
  assign tick       = (presc == PW'(CLK_DIV - 1));
  assign presc_inc  = tick ? '0 : presc + PW'(1);

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (a > b)      return W_1P;
    else if (b > a) return W_2P;
    else            return W_DRAW;
  endfunction

  // State and all registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      STATE    <= S_TITLE;
      SEC      <= '0;
      ROUND    <= '0;
      SCORE_1P <= '0;
      SCORE_2P <= '0;
      WINNER   <= W_NONE;
      presc    <= '0;
      start_q  <= 1'b1;
    end else begin
      STATE    <= state_n;
      SEC      <= sec_n;
      ROUND    <= round_n;
      SCORE_1P <= score_1p_n;
      SCORE_2P <= score_2p_n;
      WINNER   <= winner_n;
      presc    <= presc_n;
      start_q  <= START;
    end
  end

  // Next-state and next-output logic; prescaler only runs in timed states
  always_comb begin
    state_n    = STATE;
    sec_n      = SEC;
    round_n    = ROUND;
    score_1p_n = SCORE_1P;
    score_2p_n = SCORE_2P;
    winner_n   = WINNER;
    presc_n    = '0;

    case (STATE)
      S_TITLE: begin
        if (start_edge) begin
          state_n    = S_READY;
          round_n    = 2'd1;
          score_1p_n = '0;
          score_2p_n = '0;
          winner_n   = W_NONE;
          sec_n      = '0;
        end
      end

      S_READY: begin
        if (OK && OK_2) begin
          state_n = S_COUNTDOWN;
          sec_n   = 6'(COUNT_SEC);
        end
      end

      S_COUNTDOWN: begin
        presc_n = presc_inc;
        if (tick) begin
          if (SEC > 6'd1) begin
            sec_n = SEC - 6'd1;
          end else begin
            state_n = S_PLAY;
            sec_n   = 6'(PLAY_SEC);
            presc_n = '0;
          end
        end
      end

      S_PLAY: begin
        presc_n = presc_inc;
        // An answer outranks a coincident timeout tick
        if (ANS_1P || ANS_2P) begin
          state_n = S_ROUND_END;
          sec_n   = '0;
          presc_n = '0;
          if (ANS_1P && !ANS_2P) score_1p_n = sat_inc(SCORE_1P);
          if (ANS_2P && !ANS_1P) score_2p_n = sat_inc(SCORE_2P);
        end else if (tick) begin
          if (SEC > 6'd1) begin
            sec_n = SEC - 6'd1;
          end else begin
            state_n = S_ROUND_END;
            sec_n   = '0;
            presc_n = '0;
          end
        end
      end

      S_ROUND_END: begin
        presc_n = presc_inc;
        sec_n   = '0;
        if (tick) begin
          presc_n = '0;
          if (ROUND < 2'(ROUNDS)) begin
            state_n = S_READY;
            round_n = ROUND + 2'd1;
          end else begin
            state_n  = S_RESULT;
            winner_n = judge(SCORE_1P, SCORE_2P);
          end
        end
      end

      S_RESULT: begin
        if (start_edge) begin
          state_n    = S_TITLE;
          round_n    = '0;
          score_1p_n = '0;
          score_2p_n = '0;
          winner_n   = W_NONE;
        end
      end

      default: begin
        state_n    = S_TITLE;
        sec_n      = '0;
        round_n    = '0;
        score_1p_n = '0;
        score_2p_n = '0;
        winner_n   = W_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table plus randomized stimulus, both
// checked every cycle against a behavioural model of the game rules.
module tb_game_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int COUNT_SEC = 3;
  localparam int PLAY_SEC  = 5;
  localparam int ROUNDS    = 2;

  logic       CLK, RST, START, OK, OK_2, ANS_1P, ANS_2P;
  logic [3:0] STATE;
  logic [5:0] SEC;
  logic [1:0] ROUND, SCORE_1P, SCORE_2P, WINNER;

  game_ctrl #(
    .CLK_DIV(CLK_DIV), .COUNT_SEC(COUNT_SEC), .PLAY_SEC(PLAY_SEC), .ROUNDS(ROUNDS)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .OK(OK), .OK_2(OK_2),
    .ANS_1P(ANS_1P), .ANS_2P(ANS_2P), .STATE(STATE), .SEC(SEC),
    .ROUND(ROUND), .SCORE_1P(SCORE_1P), .SCORE_2P(SCORE_2P), .WINNER(WINNER)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model of the game rules
  typedef enum {M_TITLE, M_READY, M_CD, M_PLAY, M_RE, M_RES} mode_t;
  mode_t m_mode = M_TITLE;
  int m_sec = 0, m_round = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_cnt = 0;
  bit m_startq = 1'b1;

  function automatic logic [3:0] code(input mode_t m);
    case (m)
      M_TITLE: return 4'b0001;
      M_READY: return 4'b0010;
      M_CD:    return 4'b0100;
      M_PLAY:  return 4'b1000;
      M_RE:    return 4'b0011;
      default: return 4'b0101;
    endcase
  endfunction

  task automatic model(input bit rst, start, ok, ok2, a1, a2);
    bit st_edge;
    if (rst) begin
      m_mode = M_TITLE; m_sec = 0; m_round = 0; m_s1 = 0; m_s2 = 0;
      m_win = 0; m_cnt = 0; m_startq = 1'b1;
      return;
    end
    st_edge  = start && !m_startq;
    m_startq = start;
    case (m_mode)
      M_TITLE: if (st_edge) begin
        m_mode = M_READY; m_round = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
      end
      M_READY: if (ok && ok2) begin
        m_mode = M_CD; m_sec = COUNT_SEC; m_cnt = 0;
      end
      M_CD: begin
        m_cnt++;
        if (m_cnt % CLK_DIV == 0) begin
          if (m_sec > 1) m_sec--;
          else begin m_mode = M_PLAY; m_sec = PLAY_SEC; m_cnt = 0; end
        end
      end
      M_PLAY: begin
        if (a1 || a2) begin
          if (a1 && !a2 && m_s1 < 3) m_s1++;
          if (a2 && !a1 && m_s2 < 3) m_s2++;
          m_mode = M_RE; m_sec = 0; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt % CLK_DIV == 0) begin
            if (m_sec > 1) m_sec--;
            else begin m_mode = M_RE; m_sec = 0; m_cnt = 0; end
          end
        end
      end
      M_RE: begin
        m_cnt++;
        if (m_cnt == CLK_DIV) begin
          if (m_round < ROUNDS) begin m_mode = M_READY; m_round++; end
          else begin
            m_mode = M_RES;
            m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
          end
        end
      end
      M_RES: if (st_edge) begin
        m_mode = M_TITLE; m_round = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      end
      default: m_mode = M_TITLE;
    endcase
  endtask

  task automatic chk_model();
    chk("model.state", 32'(STATE), 32'(code(m_mode)));
    chk("model.sec", 32'(SEC), 32'(m_sec));
    chk("model.round", 32'(ROUND), 32'(m_round));
    chk("model.score1", 32'(SCORE_1P), 32'(m_s1));
    chk("model.score2", 32'(SCORE_2P), 32'(m_s2));
    chk("model.winner", 32'(WINNER), 32'(m_win));
  endtask

  task automatic step(input bit rst, start, ok, ok2, a1, a2);
    RST = rst; START = start; OK = ok; OK_2 = ok2; ANS_1P = a1; ANS_2P = a2;
    @(posedge CLK);
    model(rst, start, ok, ok2, a1, a2);
    #1;
    chk_model();
  endtask

  typedef struct {
    bit rst, start, ok, ok2, a1, a2;
    int n;
    logic [3:0] st;
    int sec, rnd, s1, s2, win;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, start, ok, ok2, a1, a2, input int n,
                     input logic [3:0] st, input int sec, rnd, s1, s2, win);
    vec_t v;
    v.rst = rst; v.start = start; v.ok = ok; v.ok2 = ok2; v.a1 = a1; v.a2 = a2;
    v.n = n; v.st = st; v.sec = sec; v.rnd = rnd; v.s1 = s1; v.s2 = s2; v.win = win;
    tbl.push_back(v);
  endtask

  initial begin
    bit start_lvl;
    int ans_rate;
    RST = 1'b1; START = 1'b1; OK = 1'b0; OK_2 = 1'b0; ANS_1P = 1'b0; ANS_2P = 1'b0;

    //  rst st ok o2 a1 a2  n   state    sec rnd s1 s2 win
    add(1, 1, 0, 0, 0, 0,  3, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  2, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  1, 4'b0010, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 10, 4'b0010, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1, 4'b0100, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  4, 4'b0100, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  4, 4'b0100, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  4, 4'b1000, 5, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,  1, 4'b0011, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  3, 4'b0011, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 4'b0010, 0, 2, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1, 4'b0100, 3, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 12, 4'b1000, 5, 2, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1,  1, 4'b0011, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  4, 4'b0101, 0, 2, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0,  1, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  1, 4'b0010, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1, 4'b0100, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 12, 4'b1000, 5, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 19, 4'b1000, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 4'b0011, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 4'b0011, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  3, 4'b0010, 0, 2, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1, 4'b0100, 3, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  5, 4'b0100, 2, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 4'b0001, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].rst, tbl[i].start, tbl[i].ok, tbl[i].ok2, tbl[i].a1, tbl[i].a2);
      chk($sformatf("row%0d.state", i), 32'(STATE), 32'(tbl[i].st));
      chk($sformatf("row%0d.sec", i), 32'(SEC), 32'(tbl[i].sec));
      chk($sformatf("row%0d.round", i), 32'(ROUND), 32'(tbl[i].rnd));
      chk($sformatf("row%0d.score1", i), 32'(SCORE_1P), 32'(tbl[i].s1));
      chk($sformatf("row%0d.score2", i), 32'(SCORE_2P), 32'(tbl[i].s2));
      chk($sformatf("row%0d.winner", i), 32'(WINNER), 32'(tbl[i].win));
    end

    // Randomized play; answer density varies so both answers and timeouts occur
    start_lvl = 1'b0;
    ans_rate  = 10;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: ans_rate = 3;
          1: ans_rate = 12;
          default: ans_rate = 80;
        endcase
      end
      if ($urandom_range(0, 5) == 0) start_lvl = ~start_lvl;
      step(($urandom_range(0, 399) == 0), start_lvl,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, ans_rate - 1) == 0),
           ($urandom_range(0, ans_rate - 1) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
